// File: rtl/sync_pkg.sv
// sync_pkg: shared limits and counter sizing for the synchronizer/filter slice.
package sync_pkg;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_FILTER_CYCLES = 255;
  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction
endpackage

// File: rtl/sync_filter_ch.sv
// sync_filter_ch: one channel of synchronizer chain, glitch filter and edge detector.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RST_VAL       = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("sync_filter_ch: SYNC_STAGES must be 2..4");
  end
  if (FILTER_CYCLES < 0 || FILTER_CYCLES > MAX_FILTER_CYCLES) begin : g_bad_filter
    $error("sync_filter_ch: FILTER_CYCLES must be 0..255");
  end
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hist_q;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) sync_q <= {SYNC_STAGES{RST_VAL}};
    else sync_q <= sync_d;
  assign sync_out = sync_q[SYNC_STAGES-1];
  if (FILTER_CYCLES == 0) begin : g_bypass
    assign filt_out = sync_out;
  end else begin : g_filter
    localparam int CNT_W = cnt_width(FILTER_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic filt_q, filt_d, mism, done;
    // The counter only ever counts consecutive disagreeing samples.
    always_comb begin
      mism = sync_out != filt_q;
      done = mism && (cnt_q == CNT_W'(FILTER_CYCLES - 1));
      cnt_d = (!mism || done) ? '0 : cnt_q + 1'b1;
      filt_d = done ? sync_out : filt_q;
    end
    always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
        cnt_q <= '0;
        filt_q <= RST_VAL;
      end else begin
        cnt_q <= cnt_d;
        filt_q <= filt_d;
      end
    assign filt_out = filt_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) hist_q <= RST_VAL;
    else hist_q <= filt_out;
  assign rise_pulse = filt_out & ~hist_q;
  assign fall_pulse = ~filt_out & hist_q;
endmodule

// File: rtl/sync_filter_multi.sv
// sync_filter_multi: NUM_CH independent input conditioners for asynchronous pins.
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int                NUM_CH        = 1,
  parameter int                SYNC_STAGES   = 2,
  parameter logic [NUM_CH-1:0] RESET_VAL     = {NUM_CH{1'b1}},
  parameter int                FILTER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] filt_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_VAL      (RESET_VAL[i])
    ) u_ch (
      .clk       (clk),
      .n_rst     (n_rst),
      .async_in  (async_in[i]),
      .sync_out  (sync_out[i]),
      .filt_out  (filt_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end
endmodule

// File: tb/tb_sync_filter_multi.sv
// tb_sync_filter_multi: directed vectors with a per-cycle scoreboard for a filtered and a bypass instance.
module tb_sync_filter_multi;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] a_sync, a_filt, a_rise, a_fall;
  logic [0:0] b_in = '0;
  logic [0:0] b_sync, b_filt, b_rise, b_fall;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    int step;
    logic [3:0] s, f, r, fl;
    logic bs, br, bf;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  sync_filter_multi #(.NUM_CH(4), .SYNC_STAGES(2), .RESET_VAL(4'b1010), .FILTER_CYCLES(4)) u_a (
    .clk(clk), .n_rst(n_rst), .async_in(a_in), .sync_out(a_sync),
    .filt_out(a_filt), .rise_pulse(a_rise), .fall_pulse(a_fall)
  );
  sync_filter_multi #(.NUM_CH(1), .SYNC_STAGES(3), .RESET_VAL(1'b0), .FILTER_CYCLES(0)) u_b (
    .clk(clk), .n_rst(n_rst), .async_in(b_in), .sync_out(b_sync),
    .filt_out(b_filt), .rise_pulse(b_rise), .fall_pulse(b_fall)
  );
  task automatic chk(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %b expected %b", step, name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("a_sync", e.step, a_sync, e.s);
      chk("a_filt", e.step, a_filt, e.f);
      chk("a_rise", e.step, a_rise, e.r);
      chk("a_fall", e.step, a_fall, e.fl);
      chk("b_filt", e.step, {3'b0, b_filt}, {3'b0, e.bs});
      chk("b_sync", e.step, {3'b0, b_sync}, {3'b0, e.bs});
      chk("b_rise", e.step, {3'b0, b_rise}, {3'b0, e.br});
      chk("b_fall", e.step, {3'b0, b_fall}, {3'b0, e.bf});
    end
  int step_no = 0;
  // Inputs change just after a rising edge; expectations describe outputs before the next edge.
  task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] s, input logic [3:0] f,
                      input logic [3:0] r, input logic [3:0] fl, input logic b, input logic bs,
                      input logic br, input logic bf);
    exp_t e;
    @(posedge clk);
    #1;
    n_rst = rst;
    a_in = a;
    b_in = b;
    e.step = step_no; e.s = s; e.f = f; e.r = r; e.fl = fl; e.bs = bs; e.br = br; e.bf = bf;
    q.push_back(e);
    step_no++;
  endtask
  initial begin
    // reset state, release, all-low inputs propagate (ch1/ch3 fall together)
    step(0, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 1, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0);
    // 3-cycle glitch on ch0 is rejected
    step(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
    step(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    step(1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0);
    // ch0 held high is accepted after 4 mismatching samples
    step(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0);
    step(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0);
    step(1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
    step(1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 0, 0, 0, 0);
    step(1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    // chatter: 0,0,0,1,0,0,0,0 at sync_out restarts the count
    step(1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    // ch1 counts to 2, then reset mid-count; after release the count starts over
    step(1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    step(0, 4'h2, 4'hA, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(0, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 0, 0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
